// File: rtl/rv32im_lsu_pkg.sv
// Shared encodings for the RV32IM load/store alignment front-end: funct3 values,
// memory-stage word sizes and the controller state type.
package rv32im_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rv32im_lsu_align_load_extend.sv
// Combinational sign/zero extension of an LSB-justified load value to XLEN bits.
module rv32im_load_extend
    import rv32im_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_BYTE: data_o = {{(XLEN-8){signed_i & data_i[7]}}, data_i[7:0]};
            SIZE_HALF: data_o = {{(XLEN-16){signed_i & data_i[15]}}, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/rv32im_lsu_align.sv
// Load/store front-end: decodes funct3, issues aligned accesses directly and splits
// misaligned ones into byte transactions, reassembling and extending load data.
module rv32im_lsu_align
    import rv32im_lsu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      funct3_i,
    input  logic            write_i,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic [1:0]      mem_word_size_o,
    output logic            mem_write_o,
    input  logic            mem_done_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    lsu_state_e      state_q;
    logic [XLEN-1:0] addr_q, wdata_q, acc_q, acc_d, ext_data;
    logic [1:0]      size_q;
    logic            signed_q, write_q, split_q, err_q;
    logic [2:0]      cnt_q, idx_q, idx_nxt;

    logic            done_q, mem_req_q, mem_write_q;
    logic [XLEN-1:0] rdata_q, mem_addr_q, mem_data_q;
    logic [1:0]      mem_size_q;

    logic [1:0]      dec_size;
    logic            dec_illegal, dec_misaligned;

    logic [XLEN-1:0] src_addr, src_wdata, iss_addr, iss_data;
    logic [1:0]      src_size, iss_size, src_idx;
    logic            src_split, src_write;

    always_comb begin
        dec_size    = SIZE_BYTE;
        dec_illegal = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: dec_size = SIZE_BYTE;
            F3_LH, F3_LHU: dec_size = SIZE_HALF;
            F3_LW:         dec_size = SIZE_WORD;
            default:       dec_illegal = 1'b1;
        endcase
        if (write_i && funct3_i[2]) begin
            dec_illegal = 1'b1;
        end
        dec_misaligned = ((dec_size == SIZE_HALF) && addr_i[0]) ||
                         ((dec_size == SIZE_WORD) && (addr_i[1:0] != 2'b00));
    end

    assign idx_nxt = idx_q + 3'd1;

    // The next transaction comes from the request itself in IDLE, else from latched state.
    always_comb begin
        if (state_q == StIdle) begin
            src_addr  = addr_i;
            src_wdata = wdata_i;
            src_size  = dec_size;
            src_split = dec_misaligned;
            src_write = write_i;
            src_idx   = 2'd0;
        end else begin
            src_addr  = addr_q;
            src_wdata = wdata_q;
            src_size  = size_q;
            src_split = split_q;
            src_write = write_q;
            src_idx   = idx_nxt[1:0];
        end
        iss_addr = src_split ? src_addr + XLEN'(src_idx) : src_addr;
        iss_size = src_split ? SIZE_BYTE : src_size;
        iss_data = src_split ? XLEN'(src_wdata[{src_idx, 3'b000} +: 8]) : src_wdata;
    end

    always_comb begin
        acc_d = acc_q;
        if (split_q) begin
            acc_d[{idx_q[1:0], 3'b000} +: 8] = mem_rdata_i[7:0];
        end else begin
            acc_d = mem_rdata_i;
        end
    end

    rv32im_load_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .data_i  (acc_d),
        .size_i  (size_q),
        .signed_i(signed_q),
        .data_o  (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            size_q      <= SIZE_BYTE;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 3'd0;
            idx_q       <= 3'd0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_size_q  <= SIZE_BYTE;
            mem_write_q <= 1'b0;
        end else if (clear_i) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_size_q  <= SIZE_BYTE;
            mem_write_q <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        addr_q   <= addr_i;
                        wdata_q  <= wdata_i;
                        size_q   <= dec_size;
                        signed_q <= ~funct3_i[2];
                        write_q  <= write_i;
                        split_q  <= dec_misaligned;
                        cnt_q    <= dec_misaligned ? size_bytes(dec_size) : 3'd1;
                        idx_q    <= 3'd0;
                        acc_q    <= '0;
                        if (dec_illegal) begin
                            // ISSUE is passed through without a bus request to keep
                            // the two-cycle error response.
                            err_q   <= 1'b1;
                            state_q <= StIssue;
                        end else if (dec_misaligned && !ALLOW_MISALIGNED) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            rdata_q <= '0;
                            state_q <= StResp;
                        end else begin
                            err_q       <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= iss_addr;
                            mem_data_q  <= iss_data;
                            mem_size_q  <= iss_size;
                            mem_write_q <= src_write;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (err_q) begin
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= StResp;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (mem_err_i) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        rdata_q <= '0;
                        state_q <= StResp;
                    end else if (mem_done_i) begin
                        acc_q <= acc_d;
                        idx_q <= idx_nxt;
                        if (split_q && (idx_nxt < cnt_q)) begin
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= iss_addr;
                            mem_data_q  <= iss_data;
                            mem_size_q  <= iss_size;
                            mem_write_q <= src_write;
                            state_q     <= StIssue;
                        end else begin
                            done_q  <= 1'b1;
                            rdata_q <= write_q ? '0 : ext_data;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o         = (state_q == StIdle);
    assign done_o          = done_q;
    assign err_o           = done_q & err_q;
    assign rdata_o         = rdata_q;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_data_o      = mem_data_q;
    assign mem_word_size_o = mem_size_q;
    assign mem_write_o     = mem_write_q;

endmodule
